// File: rtl/vga_sync_monitor.sv
// Measures VGA timing (line/frame geometry, sync width), checksums active pixels
// per frame, and tracks timing lock with a sticky mismatch flag.
module vga_sync_monitor (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        hsync_pol_i,
  input  logic        vsync_pol_i,
  input  logic        hblank_i,
  input  logic        vblank_i,
  input  logic [23:0] rgb_i,
  input  logic        clr_err_i,
  output logic [11:0] h_total_o,
  output logic [11:0] h_active_o,
  output logic [11:0] hs_width_o,
  output logic [10:0] v_total_o,
  output logic [10:0] v_active_o,
  output logic [31:0] frame_sum_o,
  output logic        frame_done_o,
  output logic        locked_o,
  output logic        err_o
);
  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] ACQUIRE  = 2'd1;
  localparam logic [1:0] LOCKED   = 2'd2;

  logic        hsync_q, vsync_q, hpol_q, vpol_q, hblank_q, vblank_q, clr_q;
  logic [23:0] rgb_q, rgb2_q;
  logic        hs_act_q, vs_act_q, hs_prev_q, vs_prev_q, hblank2_q, vblank2_q;
  logic [11:0] hcnt_q, hcnt_d, hact_q, hact_d, hsw_q, hsw_d;
  logic [11:0] ht_stg_q, ht_stg_d, ha_stg_q, ha_stg_d, hsw_stg_q, hsw_stg_d;
  logic [11:0] ref_q, ref_d, h_line;
  logic [10:0] vcnt_q, vcnt_d, vact_q, vact_d;
  logic [31:0] acc_q, acc_d;
  logic        ref_vld_q, ref_vld_d, fault_q, fault_d, seen_q;
  logic [1:0]  state_q, state_d;
  logic [11:0] h_total_q, h_active_q, hs_width_q;
  logic [10:0] v_total_q, v_active_q;
  logic [31:0] sum_q;
  logic        done_q, err_q, err_d, err_set;
  logic        hs_edge, hs_fall, vs_edge, upd, sat_now, line_bad, frame_fault;

  // The activity flags are registered once more (reset to 1) so no edge can be
  // invented from the cleared capture stage right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_q   <= 1'b0; vsync_q   <= 1'b0; hpol_q    <= 1'b0; vpol_q <= 1'b0;
      hblank_q  <= 1'b0; vblank_q  <= 1'b0; clr_q     <= 1'b0; rgb_q  <= '0;
      hs_act_q  <= 1'b1; vs_act_q  <= 1'b1; hs_prev_q <= 1'b1; vs_prev_q <= 1'b1;
      hblank2_q <= 1'b0; vblank2_q <= 1'b0; rgb2_q    <= '0;
    end else begin
      hsync_q   <= hsync_i;   vsync_q   <= vsync_i;
      hpol_q    <= hsync_pol_i; vpol_q  <= vsync_pol_i;
      hblank_q  <= hblank_i;  vblank_q  <= vblank_i;
      clr_q     <= clr_err_i; rgb_q     <= rgb_i;
      hs_act_q  <= (hsync_q == hpol_q);
      vs_act_q  <= (vsync_q == vpol_q);
      hs_prev_q <= hs_act_q;  vs_prev_q <= vs_act_q;
      hblank2_q <= hblank_q;  vblank2_q <= vblank_q; rgb2_q <= rgb_q;
    end
  end

  always_comb begin
    hs_edge  = hs_act_q & ~hs_prev_q;
    hs_fall  = ~hs_act_q & hs_prev_q;
    vs_edge  = vs_act_q & ~vs_prev_q;
    upd      = vs_edge & seen_q;
    h_line   = (&hcnt_q) ? hcnt_q : hcnt_q + 12'd1;
    sat_now  = (&hcnt_q) | (&hact_q) | (&hsw_q) | (&vcnt_q) | (&vact_q);
    line_bad = hs_edge & ref_vld_q & (h_line != ref_q);

    hcnt_d    = hs_edge ? 12'd0 : h_line;
    hact_d    = hs_edge ? {11'd0, ~hblank2_q}
              : (~hblank2_q & ~(&hact_q)) ? hact_q + 12'd1 : hact_q;
    ht_stg_d  = hs_edge ? h_line : ht_stg_q;
    ha_stg_d  = hs_edge ? hact_q : ha_stg_q;
    hsw_d     = ~hs_act_q ? hsw_q : hs_edge ? 12'd1 : (&hsw_q) ? hsw_q : hsw_q + 12'd1;
    hsw_stg_d = hs_fall ? hsw_q : hsw_stg_q;

    // An HS edge coincident with VS opens the new frame, so it seeds the counts.
    vcnt_d = vs_edge ? {10'd0, hs_edge}
           : (hs_edge & ~(&vcnt_q)) ? vcnt_q + 11'd1 : vcnt_q;
    vact_d = vs_edge ? {10'd0, hs_edge & ~vblank2_q}
           : (hs_edge & ~vblank2_q & ~(&vact_q)) ? vact_q + 11'd1 : vact_q;
    acc_d  = (vs_edge ? 32'd0 : acc_q) + ((~hblank2_q & ~vblank2_q) ? {8'd0, rgb2_q} : 32'd0);

    frame_fault = fault_q | sat_now;
    fault_d     = vs_edge ? 1'b0 : (fault_q | line_bad | sat_now);
    ref_vld_d   = vs_edge ? hs_edge : (ref_vld_q | hs_edge);
    ref_d       = (hs_edge & (vs_edge | ~ref_vld_q)) ? h_line : ref_q;

    state_d = state_q;
    err_set = 1'b0;
    if (upd) begin
      case (state_q)
        UNLOCKED: state_d = ACQUIRE;
        ACQUIRE:  if (!frame_fault && ht_stg_q == h_total_q && vcnt_q == v_total_q)
                    state_d = LOCKED;
        LOCKED:   if (frame_fault || vcnt_q != v_total_q) begin
                    state_d = ACQUIRE;
                    err_set = 1'b1;
                  end
        default:  state_d = UNLOCKED;
      endcase
    end
    err_d = err_set | (err_q & ~clr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q <= '0; hact_q <= '0; hsw_q <= '0; ht_stg_q <= '0; ha_stg_q <= '0;
      hsw_stg_q <= '0; ref_q <= '0; vcnt_q <= '0; vact_q <= '0; acc_q <= '0;
      ref_vld_q <= 1'b0; fault_q <= 1'b0; seen_q <= 1'b0; state_q <= UNLOCKED;
      h_total_q <= '0; h_active_q <= '0; hs_width_q <= '0; v_total_q <= '0;
      v_active_q <= '0; sum_q <= '0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d; hact_q <= hact_d; hsw_q <= hsw_d; ht_stg_q <= ht_stg_d;
      ha_stg_q <= ha_stg_d; hsw_stg_q <= hsw_stg_d; ref_q <= ref_d;
      vcnt_q <= vcnt_d; vact_q <= vact_d; acc_q <= acc_d;
      ref_vld_q <= ref_vld_d; fault_q <= fault_d; seen_q <= seen_q | vs_edge;
      state_q <= state_d; done_q <= upd; err_q <= err_d;
      if (upd) begin
        h_total_q  <= ht_stg_q;  h_active_q <= ha_stg_q; hs_width_q <= hsw_stg_q;
        v_total_q  <= vcnt_q;    v_active_q <= vact_q;   sum_q      <= acc_q;
      end
    end
  end

  assign h_total_o    = h_total_q;
  assign h_active_o   = h_active_q;
  assign hs_width_o   = hs_width_q;
  assign v_total_o    = v_total_q;
  assign v_active_o   = v_active_q;
  assign frame_sum_o  = sum_q;
  assign frame_done_o = done_q;
  assign locked_o     = (state_q == LOCKED);
  assign err_o        = err_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down raster
// (56 clk/line, 40 active, 8 sync; 31 lines/frame, 24 active) with active-low syncs.
module tb_vga_sync_monitor;
  localparam int HA = 40, HFP = 4, HSW = 8, HT = 56, HS0 = HA + HFP;
  localparam int VA = 24, VFP = 2, VSW = 2, VT = 31;

  logic        clk = 1'b0, rst, hsync, vsync, hsync_pol, vsync_pol, hblank, vblank, clr_err;
  logic [23:0] rgb;
  logic [11:0] h_total, h_active, hs_width;
  logic [10:0] v_total, v_active;
  logic [31:0] frame_sum;
  logic        frame_done, locked, err;

  int vecs = 0, errs = 0, cyc = 0, fd_cnt = 0, cyc_fd = 0, cyc_vs = 0;

  vga_sync_monitor dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync),
    .hsync_pol_i(hsync_pol), .vsync_pol_i(vsync_pol), .hblank_i(hblank), .vblank_i(vblank),
    .rgb_i(rgb), .clr_err_i(clr_err), .h_total_o(h_total), .h_active_o(h_active),
    .hs_width_o(hs_width), .v_total_o(v_total), .v_active_o(v_active),
    .frame_sum_o(frame_sum), .frame_done_o(frame_done), .locked_o(locked), .err_o(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done) begin fd_cnt <= fd_cnt + 1; cyc_fd <= cyc; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic drive(input int l, input int p, input int vs_px, input logic [23:0] pix);
    int pos;
    logic vs;
    pos = l * HT + p;
    vs  = (pos >= (VA + VFP) * HT + vs_px) && (pos < (VA + VFP + VSW) * HT + vs_px);
    @(negedge clk);
    if (vs && vsync) cyc_vs = cyc;
    hsync  = !(p >= HS0 && p < HS0 + HSW);
    vsync  = !vs;
    hblank = (p >= HA);
    vblank = (l >= VA);
    rgb    = pix;
  endtask

  // xclk extra front-porch clocks are inserted into line xline, lengthening it.
  task automatic send_lines(input int l0, input int l1, input int vs_px, input int xline,
                            input int xclk, input logic [23:0] pix);
    for (int l = l0; l < l1; l++)
      for (int p = 0; p < HT; p++) begin
        if (l == xline && p == HS0) repeat (xclk) drive(l, HS0 - 1, vs_px, pix);
        drive(l, p, vs_px, pix);
      end
  endtask

  task automatic send_frame(input int vs_px, input int xline, input int xclk, input logic [23:0] pix);
    send_lines(0, VT, vs_px, xline, xclk, pix);
  endtask

  task automatic test_reset();
    rst = 1'b1; hsync = 1'b1; vsync = 1'b1; hsync_pol = 1'b0; vsync_pol = 1'b0;
    hblank = 1'b1; vblank = 1'b1; rgb = '0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    vecs++; if ({h_total, h_active, hs_width, v_total, v_active, frame_sum, frame_done, locked, err} !== '0) begin
      errs++; $display("FAIL reset_outputs got %h want 0", {h_total, h_active, hs_width, v_total, v_active, frame_sum, frame_done, locked, err}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (fd_cnt !== 0) begin errs++; $display("FAIL first_vs_suppressed got %0d want 0", fd_cnt); end
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (fd_cnt !== 1) begin errs++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
    vecs++; if (cyc_fd - cyc_vs !== 3) begin errs++; $display("FAIL done_latency got %0d want 3", cyc_fd - cyc_vs); end
    vecs++; if (h_total !== 12'd56) begin errs++; $display("FAIL h_total got %0d want 56", h_total); end
    vecs++; if (h_active !== 12'd40) begin errs++; $display("FAIL h_active got %0d want 40", h_active); end
    vecs++; if (hs_width !== 12'd8) begin errs++; $display("FAIL hs_width got %0d want 8", hs_width); end
    vecs++; if (v_total !== 11'd31) begin errs++; $display("FAIL v_total got %0d want 31", v_total); end
    vecs++; if (v_active !== 11'd24) begin errs++; $display("FAIL v_active got %0d want 24", v_active); end
    vecs++; if (frame_sum !== 32'd960) begin errs++; $display("FAIL sum_ones got %0d want 960", frame_sum); end
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL locked_2nd_vs got %0b want 0", locked); end
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL locked_3rd_vs got %0b want 1", locked); end
    vecs++; if (fd_cnt !== 2 || err !== 1'b0) begin errs++; $display("FAIL third_frame got fd=%0d err=%0b want fd=2 err=0", fd_cnt, err); end
  endtask

  task automatic test_checksum();
    send_frame(0, -1, 0, 24'hFFFFFF);
    vecs++; if (frame_sum !== 32'd3221224512) begin errs++; $display("FAIL sum_white got %0d want 3221224512", frame_sum); end
    send_frame(0, -1, 0, 24'h123456);
    vecs++; if (frame_sum !== 32'd1145324160) begin errs++; $display("FAIL sum_123456 got %0d want 1145324160", frame_sum); end
    vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL locked_after_sums got %0b want 1", locked); end
  endtask

  task automatic test_line_fault();
    send_frame(0, 25, 1, 24'd1);
    vecs++; if (h_total !== 12'd57) begin errs++; $display("FAIL fault_h_total got %0d want 57", h_total); end
    vecs++; if (err !== 1'b1 || locked !== 1'b0) begin errs++; $display("FAIL fault_flags got err=%0b lk=%0b want err=1 lk=0", err, locked); end
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL relock_1st_clean got %0b want 0", locked); end
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (locked !== 1'b1 || err !== 1'b1) begin errs++; $display("FAIL relock_2nd_clean got lk=%0b err=%0b want lk=1 err=1", locked, err); end
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    @(negedge clk);
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL clr_err got %0b want 0", err); end
  endtask

  task automatic test_saturation();
    send_frame(0, 25, 5000, 24'd1);
    vecs++; if (h_total !== 12'd4095) begin errs++; $display("FAIL sat_h_total got %0d want 4095", h_total); end
    vecs++; if (err !== 1'b1 || locked !== 1'b0) begin errs++; $display("FAIL sat_flags got err=%0b lk=%0b want err=1 lk=0", err, locked); end
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL sat_next_frame got %0b want 0", locked); end
  endtask

  task automatic test_vs_phase();
    send_frame(HS0, -1, 0, 24'd1);
    vecs++; if (v_total !== 11'd31) begin errs++; $display("FAIL vt_into_coincident got %0d want 31", v_total); end
    send_frame(HS0, -1, 0, 24'd1);
    vecs++; if (v_total !== 11'd31 || locked !== 1'b1) begin errs++; $display("FAIL vt_coincident got %0d lk=%0b want 31 lk=1", v_total, locked); end
    send_frame(HS0 + 1, -1, 0, 24'd1);
    vecs++; if (v_total !== 11'd32) begin errs++; $display("FAIL vt_phase_shift got %0d want 32", v_total); end
    send_frame(HS0 + 1, -1, 0, 24'd1);
    vecs++; if (v_total !== 11'd31) begin errs++; $display("FAIL vt_one_later got %0d want 31", v_total); end
  endtask

  task automatic test_mid_reset();
    int n;
    send_lines(0, 10, 0, -1, 0, 24'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    vecs++; if ({h_total, h_active, hs_width, v_total, v_active, frame_sum, frame_done, locked, err} !== '0) begin
      errs++; $display("FAIL midreset_outputs got %h want 0", {h_total, h_active, hs_width, v_total, v_active, frame_sum, frame_done, locked, err}); end
    rst = 1'b0;
    n = fd_cnt;
    send_lines(10, VT, 0, -1, 0, 24'd1);
    vecs++; if (fd_cnt !== n) begin errs++; $display("FAIL midreset_first_vs got %0d want %0d", fd_cnt, n); end
    send_frame(0, -1, 0, 24'd1);
    vecs++; if (fd_cnt !== n + 1 || h_total !== 12'd56 || v_total !== 11'd31 || locked !== 1'b0) begin
      errs++; $display("FAIL midreset_next got fd=%0d ht=%0d vt=%0d lk=%0b want fd=%0d ht=56 vt=31 lk=0", fd_cnt, h_total, v_total, locked, n + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_checksum();
    test_line_fault();
    test_saturation();
    test_vs_phase();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
